// File: rtl/data_sync_fifo_pkg.sv
// Shared constants and helpers for the destination-domain data synchronizer.
package data_sync_pkg;

    localparam int DS_MODE_PULSE  = 0;
    localparam int DS_MODE_TOGGLE = 1;

    function automatic int ds_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sync_fifo_bit_sync.sv
// Single-bit flop chain into dest_clk; shared by the CDC blocks.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic dest_clk,
    input  logic dest_rst,
    input  logic i_d,
    output logic o_q
);

    logic [NUM_STAGES-1:0] r_chain;

    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[NUM_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_fifo.sv
// Captures unsync_bus into a small FIFO on each synchronized bus_enable event
// and drains it over valid/ready, returning an ack toggle per popped word.
module data_sync_fifo
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int DEPTH      = 4,
    parameter int MODE       = DS_MODE_PULSE
) (
    input  logic                     dest_clk,
    input  logic                     dest_rst,
    input  logic [BUS_WIDTH-1:0]     unsync_bus,
    input  logic                     bus_enable,
    input  logic                     sync_ready,
    output logic [BUS_WIDTH-1:0]     sync_bus,
    output logic                     sync_valid,
    output logic                     ack_toggle,
    output logic                     overflow,
    output logic [ds_clog2(DEPTH):0] fill_level
);

    localparam int            PW          = ds_clog2(DEPTH);
    localparam int            LW          = PW + 1;
    localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
    localparam logic [2:0]    SETTLE_INIT = 3'(NUM_STAGES);

    logic                 w_en_sync;
    logic                 r_en_prev;
    logic                 r_armed;
    logic [2:0]           r_settle;
    logic                 w_event;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [PW-1:0]        w_rptr_nxt;
    logic [LW-1:0]        r_fill;
    logic [BUS_WIDTH-1:0] r_mem [DEPTH];
    logic [BUS_WIDTH-1:0] r_head;
    logic                 r_ack;
    logic                 r_ovf;

    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_en_sync (
        .dest_clk(dest_clk),
        .dest_rst(dest_rst),
        .i_d     (bus_enable),
        .o_q     (w_en_sync)
    );

    // Pulse mode only arms after en_sync has been seen low once the chain has
    // flushed its reset value, so a level held high across reset is ignored.
    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) begin
            r_en_prev <= 1'b0;
            r_settle  <= SETTLE_INIT;
            r_armed   <= 1'b0;
        end else begin
            r_en_prev <= w_en_sync;
            if (r_settle != 3'd0) begin
                r_settle <= r_settle - 3'd1;
            end else if (!w_en_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        if (MODE == DS_MODE_TOGGLE) begin
            w_event = w_en_sync ^ r_en_prev;
        end else begin
            w_event = w_en_sync & ~r_en_prev & r_armed;
        end
    end

    assign w_empty    = (r_fill == '0);
    assign w_full     = (r_fill == FULL_LVL);
    assign w_pop      = ~w_empty & sync_ready;
    assign w_push     = w_event & (~w_full | w_pop);
    assign w_drop     = w_event & w_full & ~w_pop;
    assign w_rptr_nxt = r_rptr + PW'(1);

    always_ff @(posedge dest_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= unsync_bus;
        end
    end

    // r_head mirrors the entry at the read pointer but keeps the last popped
    // word while empty, so sync_bus never exposes unwritten memory.
    always_ff @(posedge dest_clk or negedge dest_rst) begin
        if (!dest_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
            r_head <= '0;
            r_ack  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
                r_ack  <= ~r_ack;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + LW'(1);
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - LW'(1);
            end
            if (w_push && w_empty) begin
                r_head <= unsync_bus;
            end else if (w_pop) begin
                if (r_fill == LW'(1)) begin
                    if (w_push) begin
                        r_head <= unsync_bus;
                    end
                end else begin
                    r_head <= r_mem[w_rptr_nxt];
                end
            end
        end
    end

    assign sync_bus   = r_head;
    assign sync_valid = ~w_empty;
    assign ack_toggle = r_ack;
    assign overflow   = r_ovf;
    assign fill_level = r_fill;

endmodule

// File: doc/data_sync_fifo.md
# data_sync_fifo

Destination-domain multi-word data synchronizer. A single-bit `bus_enable` qualifier is brought into `dest_clk` through a configurable flop chain; each detected transfer event captures `unsync_bus` into a small FIFO. The FIFO drains through a valid/ready interface. An acknowledge toggle is returned to the source domain for end-to-end flow control. It sits at clock-domain boundaries where the source can issue back-to-back transfers or the consumer can stall.

## Interface
- `BUS_WIDTH`, 8: width of `unsync_bus` / `sync_bus`.
- `NUM_STAGES`, 2: synchronizer flop count on `bus_enable`; legal values 2 to 4.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `MODE`, 0: event detection. 0 = pulse mode, one transfer per rising edge of `bus_enable`. 1 = toggle mode, one transfer per any edge of `bus_enable`.

Ports:
- `dest_clk` input, 1: destination clock.
- `dest_rst` input, 1: reset, asynchronous, active-low.
- `unsync_bus` input, BUS_WIDTH: source data. It is stable from before the `bus_enable` event until that event is acknowledged.
- `bus_enable` input, 1: source qualifier (level or toggle, per MODE).
- `sync_ready` input, 1: consumer accepts head word.
- `sync_bus` output, BUS_WIDTH: FIFO head word.
- `sync_valid` output, 1: FIFO non-empty.
- `ack_toggle` output, 1: flips once per word popped.
- `overflow` output, 1: sticky; set when an event is dropped.
- `fill_level` output, clog2(DEPTH)+1: current occupancy.

## Operation
- **Synchronizer:** `bus_enable` passes through the NUM_STAGES chain. Its last stage is `en_sync`. One further flop holds `en_prev`.
- **Event detection** (combinational):
  - MODE 0: `event = en_sync & ~en_prev`.
  - MODE 1: `event = en_sync ^ en_prev`.
- **Push:** occurs on `event` when `fill_level < DEPTH`, or when `fill_level == DEPTH` and a pop occurs in the same cycle. The pushed word is `unsync_bus` sampled at that `dest_clk` edge.
- **Drop:** `event` while full with no simultaneous pop drops the word. `overflow` is set and stays set until reset. The FIFO contents are unchanged.
- **Pop:** occurs when `sync_valid & sync_ready`. The read pointer advances and `ack_toggle` inverts.
- **Outputs:** `sync_bus` is the memory entry at the read pointer. When empty, `sync_bus` holds the last popped value (or 0 after reset). It is never X.
- **Pointers:** clog2(DEPTH) bits wide; wrap modulo DEPTH.
- **Occupancy:** `fill_level` increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- **Empty-FIFO push and pop:** a simultaneous push and pop is impossible when empty, because pop requires `sync_valid`. A push into an empty FIFO becomes visible on the next cycle.
- **Reset (async, mid-operation allowed):**
  - All pointers, `fill_level`, and sync flops clear to 0.
  - `sync_valid`, `overflow`, and `ack_toggle` go to 0, and `sync_bus` to 0.
  - FIFO memory contents need no reset.
  - An in-flight `bus_enable` edge is lost. With `bus_enable` high at release in MODE 0, no event is generated until it falls and rises again. In MODE 1 a level already high at reset release is seen as one event, once it propagates.

## Timing
- Edge k is the first `dest_clk` edge sampling a new `bus_enable` level.
- `en_sync` updates at edge k+NUM_STAGES-1, so `event` is high during the following cycle.
- The push occurs at edge k+NUM_STAGES, and `sync_valid` rises after it. Latency is NUM_STAGES+1 edges; with NUM_STAGES=2, that is 3 edges.
- `event` lasts exactly one cycle per edge of `bus_enable`.
- Minimum source event spacing is 2 `dest_clk` periods plus synchronizer uncertainty. Closer events are not guaranteed to resolve.
- `ack_toggle` is registered. It changes at the edge that completes the pop.
- `overflow` asserts at the edge of the dropped push.
- `sync_valid` and `fill_level` are registered; they reflect state after the edge.
- `sync_bus` changes only after a push into an empty FIFO or after a pop.

## Structure
- **Shared package `data_sync_pkg`:**
  - constants `DS_MODE_PULSE = 0` and `DS_MODE_TOGGLE = 1`;
  - function `ds_clog2` for pointer and level widths.
- **Sub-module `bit_sync`:** parameter `NUM_STAGES`, with the same reset. It is a single-bit flop chain reused for `bus_enable` and by other CDC blocks.
- **Top level:** edge detector, FIFO memory, pointers, level counter, overflow, and ack logic stay in the top module.

## Test plan
- **Single transfer:** MODE 0, NUM_STAGES 2. `unsync_bus = 8'hA5`, `bus_enable` rises → `sync_valid` is high 3 edges later with `sync_bus = 8'hA5`. With `sync_ready = 1`, the pop occurs and `ack_toggle` goes 0→1.
- **Toggle mode burst:** MODE 1. Four `bus_enable` edges spaced 4 clocks, carrying 11, 22, 33, 44, with `sync_ready = 0` → `fill_level = 4`. Draining with `sync_ready = 1` gives 11, 22, 33, 44 in order, and `ack_toggle` toggles 4 times.
- **Overflow:** DEPTH 4, full, `sync_ready = 0`, fifth event with 55 → `overflow = 1`, `fill_level` stays 4, and the drained data excludes 55. `overflow` remains 1 after draining.
- **Full with simultaneous push and pop:** FIFO full, event coincides with `sync_ready = 1` → no overflow, `fill_level` stays 4, and the new word appears last in the drain order.
- **Pointer wrap:** 10 sequential transfers 1 to 10 through DEPTH 4 with random `sync_ready` → output sequence is exactly 1 to 10, with no overflow.
- **Reset mid-operation:** assert `dest_rst` low with `fill_level = 3` and `bus_enable` high (MODE 0) → all outputs are 0 immediately. After release, no event occurs until `bus_enable` falls and rises again.
